// File: rtl/pes_stream_reverser.sv
// pes_stream_reverser: buffers one frame of up to DEPTH words, delimited by
// s_last, then emits it in reverse arrival order (last word first).
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   input stream (valid/ready)
//   m_data/m_valid/m_last/m_ready   output stream (valid/ready)
//   overflow        one-cycle pulse when a frame is truncated at DEPTH words
module pes_stream_reverser #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_wr_idx;
    logic [AW-1:0]    r_rd_idx;
    logic [WIDTH-1:0] r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_overflow;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_accept;
    logic             w_full;
    logic             w_frame_end;

    // s_ready is forced low during reset so nothing is accepted on that edge
    assign s_ready     = (r_state == ST_FILL) && !rst;
    assign w_accept    = s_valid && s_ready;
    assign w_full      = (r_wr_idx == AW'(DEPTH - 1));
    assign w_frame_end = s_last || w_full;

    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign m_last   = r_m_last;
    assign overflow = r_overflow;

    // Frame buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_idx] <= s_data;
        end
    end

    // FSM with registered outputs. The final word of a frame bypasses the
    // buffer so it is presented in the very next cycle; r_rd_idx then points
    // at the next slot to present.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_frame_end) begin
                            r_state    <= ST_DRAIN;
                            r_m_valid  <= 1'b1;
                            r_m_data   <= s_data;
                            r_m_last   <= (r_wr_idx == '0);
                            r_rd_idx   <= (r_wr_idx == '0) ? '0 : r_wr_idx - AW'(1);
                            r_overflow <= w_full && !s_last;
                        end else begin
                            r_wr_idx <= r_wr_idx + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        if (r_m_last) begin
                            r_state   <= ST_FILL;
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_wr_idx  <= '0;
                        end else begin
                            r_m_data <= r_mem[r_rd_idx];
                            r_m_last <= (r_rd_idx == '0);
                            if (r_rd_idx != '0) begin
                                r_rd_idx <= r_rd_idx - AW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pes_stream_reverser.sv
// Directed testbench for pes_stream_reverser (WIDTH=8, DEPTH=16).
module tb_pes_stream_reverser;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       overflow;

    pes_stream_reverser #(.WIDTH(8), .DEPTH(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .overflow (overflow)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
        bit         gap;
    } tx_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       o;
        int         c;
    } beat_t;

    tx_t   tx_q[$];
    beat_t rx_q[$];
    beat_t ex_q[$];

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         ovf_n    = 0;
    int         last_acc_cyc = 0;
    int         rdy_mode = 0;
    logic [7:0] lfsr     = 8'hA7;
    bit         prev_stall = 0;
    logic [7:0] prev_d;
    logic       prev_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Output monitor: drives m_ready, records transfers, checks hold-on-stall
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_d));
                chk("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (overflow) ovf_n++;
            m_ready = (rdy_mode == 0) ? 1'b1 : lfsr[0];
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (m_valid) chk("s_ready_in_drain", 32'(s_ready), 32'd0);
            if (m_valid && m_ready)
                rx_q.push_back('{d: m_data, l: m_last, o: overflow, c: cyc});
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
    end

    task automatic add(input logic [7:0] d, input logic l, input bit gap);
        tx_q.push_back('{d: d, l: l, gap: gap});
    endtask

    task automatic add_ex(input logic [7:0] d, input logic l, input logic o);
        ex_q.push_back('{d: d, l: l, o: o, c: 0});
    endtask

    // Drive every queued word, holding each until it is accepted
    task automatic send_all();
        foreach (tx_q[i]) begin
            int k;
            if (tx_q[i].gap) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = 8'hEE;
                s_last  = 1'b1;
                @(posedge clk); #1;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = tx_q[i].d;
            s_last  = tx_q[i].l;
            k = 0;
            while (!s_ready && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (!s_ready) chk("accept_timeout", 32'(s_ready), 32'd1);
            last_acc_cyc = cyc;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tx_q.delete();
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (rx_q.size() < n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("beat_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic compare_beats(input string tag);
        int n;
        n = (rx_q.size() < ex_q.size()) ? rx_q.size() : ex_q.size();
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(ex_q.size()));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), 32'(rx_q[i].d), 32'(ex_q[i].d));
            chk($sformatf("%s_last[%0d]", tag, i), 32'(rx_q[i].l), 32'(ex_q[i].l));
            chk($sformatf("%s_ovf[%0d]", tag, i), 32'(rx_q[i].o), 32'(ex_q[i].o));
        end
        rx_q.delete();
        ex_q.delete();
    endtask

    initial begin
        int ovf_base;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Basic 4-word frame
        add(8'h11, 0, 0); add(8'h22, 0, 0); add(8'h33, 0, 0); add(8'h44, 1, 0);
        send_all();
        wait_beats(4);
        @(negedge clk);
        chk("basic_turnaround_s_ready", 32'(s_ready), 32'd1);
        chk("basic_latency", 32'(rx_q[0].c), 32'(last_acc_cyc + 1));
        for (int i = 1; i < 4; i++)
            chk("basic_consecutive", 32'(rx_q[i].c), 32'(rx_q[0].c + i));
        add_ex(8'h44, 0, 0); add_ex(8'h33, 0, 0); add_ex(8'h22, 0, 0); add_ex(8'h11, 1, 0);
        compare_beats("basic");

        // Single-word frame
        add(8'hA5, 1, 0);
        send_all();
        wait_beats(1);
        add_ex(8'hA5, 1, 0);
        compare_beats("single");

        // Overflow: 20 words, truncated at 16, remainder is the next frame
        ovf_base = ovf_n;
        for (int i = 0; i < 20; i++) add(8'(i), (i == 19), 0);
        send_all();
        wait_beats(20);
        for (int i = 15; i >= 0; i--) add_ex(8'(i), (i == 0), (i == 15));
        add_ex(8'd19, 0, 0); add_ex(8'd18, 0, 0); add_ex(8'd17, 0, 0); add_ex(8'd16, 1, 0);
        compare_beats("ovf");
        chk("ovf_pulse_count", 32'(ovf_n - ovf_base), 32'd1);

        // Backpressure with input gaps
        rdy_mode = 1;
        add(8'hC0, 0, 0); add(8'hC1, 0, 1); add(8'hC2, 0, 0); add(8'hC3, 0, 1);
        add(8'hC4, 0, 1); add(8'hC5, 0, 0); add(8'hC6, 0, 1); add(8'hC7, 1, 0);
        send_all();
        wait_beats(8);
        add_ex(8'hC7, 0, 0); add_ex(8'hC6, 0, 0); add_ex(8'hC5, 0, 0); add_ex(8'hC4, 0, 0);
        add_ex(8'hC3, 0, 0); add_ex(8'hC2, 0, 0); add_ex(8'hC1, 0, 0); add_ex(8'hC0, 1, 0);
        compare_beats("bp");
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-drain after two of six words
        for (int i = 0; i < 6; i++) add(8'h50 + 8'(i), (i == 5), 0);
        send_all();
        wait_beats(2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        add_ex(8'h55, 0, 0); add_ex(8'h54, 0, 0);
        compare_beats("pre_rst");
        add(8'h01, 0, 0); add(8'h02, 0, 0); add(8'h03, 1, 0);
        send_all();
        wait_beats(3);
        add_ex(8'h03, 0, 0); add_ex(8'h02, 0, 0); add_ex(8'h01, 1, 0);
        compare_beats("post_rst");

        // Exactly full-depth frame: no overflow
        ovf_base = ovf_n;
        for (int i = 0; i < 16; i++) add(8'h80 + 8'(i), (i == 15), 0);
        send_all();
        wait_beats(16);
        for (int i = 15; i >= 0; i--) add_ex(8'h80 + 8'(i), (i == 0), 0);
        compare_beats("full");
        repeat (2) @(negedge clk);
        chk("full_no_overflow", 32'(ovf_n - ovf_base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
